// File: rtl/jsoc_sysid_checker.sv
// Avalon-MM master that reads the sysid ID (offset 0) and timestamp (offset 1) words and compares them to build-time values.
// Define JSOC_SYSID_AUTOSTART_EN to run one check automatically on the first cycle after reset.
module jsoc_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1711268164,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_INIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {IDLE, RD_ID, WT_ID, RD_TS, WT_TS, CHECK, FIN} state_t;

  state_t      state, state_nxt;
  logic [15:0] tmo_cnt;
  logic [3:0]  retry_cnt;
  logic        start_eff;
  logic        tmo_hit, give_up;
  logic        cap_id, cap_ts, retry_load, retry_dec, tmo_clr, tmo_set;

`ifdef JSOC_SYSID_AUTOSTART_EN
  logic boot_pend;

  always_ff @(posedge clock) begin
    if (reset) boot_pend <= 1'b1;
    else       boot_pend <= 1'b0;
  end

  assign start_eff = start | boot_pend;
`else
  assign start_eff = start;
`endif

  always_comb begin
    state_nxt  = state;
    cap_id     = 1'b0;
    cap_ts     = 1'b0;
    retry_load = 1'b0;
    retry_dec  = 1'b0;
    tmo_clr    = 1'b0;
    tmo_set    = 1'b0;
    give_up    = 1'b0;
    tmo_hit    = (tmo_cnt >= TMO_LAST);
    case (state)
      IDLE: begin
        if (start_eff) begin
          state_nxt  = RD_ID;
          retry_load = 1'b1;
          tmo_clr    = 1'b1;
        end
      end
      // An accepted command takes priority over an expiring attempt counter.
      RD_ID: begin
        if (!avm_waitrequest) state_nxt = WT_ID;
        else if (tmo_hit)     give_up   = 1'b1;
      end
      WT_ID: begin
        if (avm_readdatavalid) begin
          cap_id     = 1'b1;
          retry_load = 1'b1;
          tmo_clr    = 1'b1;
          state_nxt  = RD_TS;
        end else if (tmo_hit) begin
          give_up = 1'b1;
        end
      end
      RD_TS: begin
        if (!avm_waitrequest) state_nxt = WT_TS;
        else if (tmo_hit)     give_up   = 1'b1;
      end
      WT_TS: begin
        if (avm_readdatavalid) begin
          cap_ts    = 1'b1;
          state_nxt = CHECK;
        end else if (tmo_hit) begin
          give_up = 1'b1;
        end
      end
      CHECK:   state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Expired attempt: reissue the same word while retries remain, else abort.
    if (give_up) begin
      if (retry_cnt != 4'd0) begin
        retry_dec = 1'b1;
        tmo_clr   = 1'b1;
        state_nxt = (state == RD_ID || state == WT_ID) ? RD_ID : RD_TS;
      end else begin
        tmo_set   = 1'b1;
        state_nxt = FIN;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      retry_cnt   <= '0;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      captured_id <= '0;
      captured_ts <= '0;
    end else begin
      state <= state_nxt;
      if (tmo_clr)
        tmo_cnt <= '0;
      else if (state inside {RD_ID, WT_ID, RD_TS, WT_TS})
        tmo_cnt <= tmo_cnt + 16'd1;
      if (retry_load)     retry_cnt <= RETRY_INIT;
      else if (retry_dec) retry_cnt <= retry_cnt - 4'd1;
      // Outputs are decoded from the next state so they leave flops aligned with it.
      avm_read    <= (state_nxt == RD_ID) || (state_nxt == RD_TS);
      avm_address <= (state_nxt == RD_TS);
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == FIN);
      if (state == IDLE && start_eff) begin
        id_ok       <= 1'b0;
        ts_ok       <= 1'b0;
        timeout_err <= 1'b0;
        captured_id <= '0;
        captured_ts <= '0;
      end
      if (cap_id) captured_id <= avm_readdata;
      if (cap_ts) captured_ts <= avm_readdata;
      if (state == CHECK) begin
        id_ok <= (captured_id == EXPECTED_ID);
        ts_ok <= (captured_ts == EXPECTED_TS);
      end
      if (tmo_set) timeout_err <= 1'b1;
    end
  end

endmodule
